// File: rtl/line_buffer_ctrl.sv
// Raster sequencer for two cascaded 1-bit line-buffer RAMs; assembles a binary
// 3x3 window with centre coordinates, two cycles after each accepted pixel.
module line_buffer_ctrl #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480,
    localparam int AddrWidth  = $clog2(ImageWidth + 1),
    localparam int RowWidth   = $clog2(ImageHeight + 1)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 PixelValid,
    input  logic                 PixelIn,
    input  logic                 FrameStart,
    output logic [AddrWidth-1:0] RamAddr,
    output logic                 RamWriteEnable,
    output logic                 RamDataIn,
    input  logic                 Row0Data,
    input  logic                 Row1Data,
    output logic [8:0]           Window,
    output logic                 WindowValid,
    output logic [AddrWidth-1:0] CenterCol,
    output logic [RowWidth-1:0]  CenterRow,
    output logic                 FrameDone
);

    logic [AddrWidth-1:0] ColCount;
    logic [RowWidth-1:0]  RowCount;
    logic                 PixReg;
    logic                 CapValid;
    logic [AddrWidth-1:0] CapCol;
    logic [RowWidth-1:0]  CapRow;

    logic [AddrWidth-1:0] pixCol;
    logic [RowWidth-1:0]  pixRow;
    logic [AddrWidth-1:0] nextCol;
    logic [RowWidth-1:0]  nextRow;

    // Coordinate of the pixel on the input this cycle; FrameStart forces (0,0).
    always_comb begin
        pixCol  = ColCount;
        pixRow  = RowCount;
        if (FrameStart) begin
            pixCol = '0;
            pixRow = '0;
        end
        nextCol = pixCol + AddrWidth'(1);
        nextRow = pixRow;
        if (pixCol == AddrWidth'(ImageWidth - 1)) begin
            nextCol = '0;
            if (pixRow == RowWidth'(ImageHeight - 1)) begin
                nextRow = '0;
            end else begin
                nextRow = pixRow + RowWidth'(1);
            end
        end
    end

    assign RamAddr        = (FrameStart && PixelValid) ? '0 : ColCount;
    assign RamWriteEnable = PixelValid;
    assign RamDataIn      = PixReg;

    // Acceptance stage: the RAMs latch address/WE on this edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ColCount <= '0;
            RowCount <= '0;
            PixReg   <= 1'b0;
            CapValid <= 1'b0;
            CapCol   <= '0;
            CapRow   <= '0;
        end else begin
            CapValid <= PixelValid;
            if (PixelValid) begin
                PixReg   <= PixelIn;
                CapCol   <= pixCol;
                CapRow   <= pixRow;
                ColCount <= nextCol;
                RowCount <= nextRow;
            end
        end
    end

    // Capture stage: taps are only valid in the cycle right after acceptance,
    // before the pending write lands on the same address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Window      <= '0;
            WindowValid <= 1'b0;
            CenterCol   <= '0;
            CenterRow   <= '0;
            FrameDone   <= 1'b0;
        end else begin
            WindowValid <= CapValid && (CapCol >= AddrWidth'(2)) && (CapRow >= RowWidth'(2));
            FrameDone   <= CapValid && (CapCol == AddrWidth'(ImageWidth - 1))
                                    && (CapRow == RowWidth'(ImageHeight - 1));
            if (CapValid) begin
                Window    <= {Window[7:6], Row1Data,
                              Window[4:3], Row0Data,
                              Window[1:0], PixReg};
                CenterCol <= CapCol - AddrWidth'(1);
                CenterRow <= CapRow - RowWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl: behavioural RAM pair plus a golden
// image model checked against every flagged window.
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          PixelValid = 1'b0;
    logic          PixelIn = 1'b0;
    logic          FrameStart = 1'b0;
    logic [AW-1:0] RamAddr;
    logic          RamWriteEnable;
    logic          RamDataIn;
    logic          Row0Data;
    logic          Row1Data;
    logic [8:0]    Window;
    logic          WindowValid;
    logic [AW-1:0] CenterCol;
    logic [RW-1:0] CenterRow;
    logic          FrameDone;

    always #5 Clock = ~Clock;

    line_buffer_ctrl #(.ImageWidth(W), .ImageHeight(H)) dut (
        .Clock(Clock), .Reset(Reset), .PixelValid(PixelValid), .PixelIn(PixelIn),
        .FrameStart(FrameStart), .RamAddr(RamAddr), .RamWriteEnable(RamWriteEnable),
        .RamDataIn(RamDataIn), .Row0Data(Row0Data), .Row1Data(Row1Data),
        .Window(Window), .WindowValid(WindowValid), .CenterCol(CenterCol),
        .CenterRow(CenterRow), .FrameDone(FrameDone)
    );

    // Two RAMs with registered address/WE; RAM1 is fed from RAM0's output.
    bit            mem0 [2**AW];
    bit            mem1 [2**AW];
    logic [AW-1:0] ramAddrReg = '0;
    logic          ramWeReg = 1'b0;
    always @(posedge Clock) begin
        ramAddrReg <= RamAddr;
        ramWeReg   <= RamWriteEnable;
        if (ramWeReg) begin
            mem0[ramAddrReg] <= RamDataIn;
            mem1[ramAddrReg] <= mem0[ramAddrReg];
        end
    end
    assign Row0Data = mem0[ramAddrReg];
    assign Row1Data = mem1[ramAddrReg];

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int nVec = 0;
    int nFail = 0;

    task automatic check(string name, int act, int exp);
        nVec++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    bit img [H][W];

    function automatic bit pixFn(int pat, int x, int y, int f);
        case (pat)
            0:       return 1'b1;
            1:       return ((x + 3 * y) % 2) == 1;
            default: return ((x * 7 + y * 13 + f * 5) % 3) == 0;
        endcase
    endfunction

    function automatic logic [8:0] golden(int cx, int cy);
        logic [8:0] g;
        g = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                g[8 - (r * 3 + c)] = img[cy - 1 + r][cx - 1 + c];
        return g;
    endfunction

    bit monOn = 1'b0;
    int winCount = 0;
    int doneCount = 0;
    int oneOneCyc = 0;
    int lastDriveCyc = 0;
    int acc22 = 0;

    always @(negedge Clock) begin : monitor
        int  cx, cy, nx, ny;
        bit  inRange;
        int  prevCx = W - 2;
        int  prevCy = H - 2;
        if (monOn && !Reset) begin
            if (WindowValid) begin
                cx = int'(CenterCol);
                cy = int'(CenterRow);
                winCount++;
                inRange = (cx >= 1) && (cx <= W - 2) && (cy >= 1) && (cy <= H - 2);
                check("centreRange", int'(inRange), 1);
                if (inRange) check("window", int'(Window), int'(golden(cx, cy)));
                nx = prevCx + 1;
                ny = prevCy;
                if (nx > W - 2) begin nx = 1; ny++; end
                if (ny > H - 2) ny = 1;
                check("windowOrder", int'((cx == nx && cy == ny) || (cx == 1 && cy == 1)), 1);
                prevCx = cx;
                prevCy = cy;
                if (cx == 1 && cy == 1) oneOneCyc = cyc;
            end
            if (WindowValid || FrameDone) begin
                check("frameDone", int'(FrameDone),
                      int'(WindowValid && int'(CenterCol) == W - 2 && int'(CenterRow) == H - 2));
                if (FrameDone) doneCount++;
            end
        end
    end

    task automatic drivePix(int x, int y, bit fs, int pat, int f);
        bit p;
        p = pixFn(pat, x, y, f);
        img[y][x] = p;
        PixelValid = 1'b1;
        PixelIn = p;
        FrameStart = fs;
        lastDriveCyc = cyc;
        @(negedge Clock);
        check("RamAddr", int'(RamAddr), x);
        check("RamWriteEnable", int'(RamWriteEnable), 1);
        @(posedge Clock); #1;
        PixelValid = 1'b0;
        FrameStart = 1'b0;
        PixelIn = 1'b0;
    endtask

    // Idle cycles: FrameStart toggles randomly and must be ignored.
    task automatic idle(int n, int expAddr);
        for (int i = 0; i < n; i++) begin
            FrameStart = 1'($urandom_range(0, 1));
            @(negedge Clock);
            check("idleWE", int'(RamWriteEnable), 0);
            check("idleAddr", int'(RamAddr), expAddr);
            @(posedge Clock); #1;
        end
        FrameStart = 1'b0;
    endtask

    task automatic runPixels(int pat, int f, bit gaps, int lastIdx);
        for (int idx = 0; idx <= lastIdx; idx++) begin
            int x, y, g;
            x = idx % W;
            y = idx / W;
            g = 0;
            if (gaps)
                while (g < 6 && $urandom_range(0, 1) == 1) begin
                    idle(1, x);
                    g++;
                end
            drivePix(x, y, idx == 0, pat, f);
            if (idx == 2 * W + 2) acc22 = lastDriveCyc;
        end
    endtask

    task automatic checkZeros(string tag);
        check({tag, "_Window"}, int'(Window), 0);
        check({tag, "_WindowValid"}, int'(WindowValid), 0);
        check({tag, "_CenterCol"}, int'(CenterCol), 0);
        check({tag, "_CenterRow"}, int'(CenterRow), 0);
        check({tag, "_FrameDone"}, int'(FrameDone), 0);
        check({tag, "_RamAddr"}, int'(RamAddr), 0);
        check({tag, "_RamWE"}, int'(RamWriteEnable), 0);
    endtask

    typedef struct {
        int pat;
        bit gaps;
        int frames;
        int expWin;
        int expDone;
    } vec_t;

    initial begin
        vec_t tbl [4];
        tbl[0] = '{pat: 0, gaps: 1'b0, frames: 1, expWin: 24, expDone: 1};
        tbl[1] = '{pat: 1, gaps: 1'b0, frames: 1, expWin: 24, expDone: 1};
        tbl[2] = '{pat: 1, gaps: 1'b1, frames: 1, expWin: 24, expDone: 1};
        tbl[3] = '{pat: 2, gaps: 1'b0, frames: 2, expWin: 48, expDone: 2};

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkZeros("reset");
        @(posedge Clock); #1;
        Reset = 1'b0;
        monOn = 1'b1;

        for (int t = 0; t < 4; t++) begin
            winCount = 0;
            doneCount = 0;
            for (int f = 0; f < tbl[t].frames; f++)
                runPixels(tbl[t].pat, t * 2 + f, tbl[t].gaps, W * H - 1);
            idle(4, 0);
            check($sformatf("vec%0d_windows", t), winCount, tbl[t].expWin);
            check($sformatf("vec%0d_frameDone", t), doneCount, tbl[t].expDone);
            check($sformatf("vec%0d_latency", t), oneOneCyc - acc22, 2);
        end

        // Reset mid-row 3 with a pixel presented in the same cycle (dropped).
        runPixels(1, 10, 1'b0, 3 * W + 3);
        Reset = 1'b1;
        PixelValid = 1'b1;
        PixelIn = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        PixelValid = 1'b0;
        PixelIn = 1'b0;
        @(negedge Clock);
        checkZeros("midReset");
        @(posedge Clock); #1;
        idle(2, 0);
        winCount = 0;
        doneCount = 0;
        runPixels(2, 11, 1'b0, W * H - 1);
        idle(4, 0);
        check("afterReset_windows", winCount, 24);
        check("afterReset_frameDone", doneCount, 1);
        check("afterReset_latency", oneOneCyc - acc22, 2);

        // FrameStart arriving at pixel (5,2) of a running frame.
        winCount = 0;
        doneCount = 0;
        runPixels(2, 12, 1'b0, 2 * W + 4);
        runPixels(2, 13, 1'b0, W * H - 1);
        idle(4, 0);
        check("restart_windows", winCount, 27);
        check("restart_frameDone", doneCount, 1);
        check("restart_latency", oneOneCyc - acc22, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
